hex_word_tx: RTL and testbench



---
 rtl/hex_word_tx.sv | 101 ++++++++++
 tb/tb_hex_word_tx.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_word_tx.sv
// hex_word_tx: FIFO-buffered transmitter that prints each data word as ASCII hex
// (MSB nibble first) with optional prefix and line ending onto the rs232out byte interface.
module hex_word_tx #(
  parameter int         WIDTH     = 36,
  parameter int         DEPTH     = 4,
  parameter bit         LOWERCASE = 1'b0,
  parameter int         EOL       = 2,
  parameter logic [7:0] PREFIX    = 8'h00
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic [7:0]             tx_data,
  output logic                   tx_we,
  input  logic                   tx_busy,
  output logic                   idle,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int NIB = (WIDTH + 3) / 4;
  localparam int SW  = NIB * 4;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(NIB + 1);

  typedef enum logic [2:0] {S_IDLE, S_PREFIX, S_DIGIT, S_CR, S_LF} state_t;

  localparam state_t S_EOL   = EOL == 2 ? S_CR : EOL == 1 ? S_LF : S_IDLE;
  localparam state_t S_FIRST = PREFIX != 8'h00 ? S_PREFIX : S_DIGIT;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      count_q;
  state_t           state_q, state_d;
  logic [SW-1:0]    sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       tx_data_q;
  logic             tx_we_q, push, pop, consume;

  function automatic logic [7:0] char_of(state_t s, logic [SW-1:0] sh);
    logic [3:0] n;
    n = sh[SW-1 -: 4];
    return s == S_PREFIX ? PREFIX :
           s == S_CR     ? 8'h0D :
           s == S_LF     ? 8'h0A :
           n < 4'd10     ? 8'h30 + {4'h0, n} :
           (LOWERCASE ? 8'h57 : 8'h37) + {4'h0, n};
  endfunction

  assign in_ready   = count_q < (AW+1)'(DEPTH);
  assign push       = in_valid && in_ready;
  assign pop        = state_q == S_IDLE && count_q != '0;
  assign consume    = tx_we_q && !tx_busy;
  assign tx_data    = tx_data_q;
  assign tx_we      = tx_we_q;
  assign fifo_count = count_q;
  assign idle       = state_q == S_IDLE && count_q == '0;

  // Where the FSM moves once the byte currently on the wire is taken.
  always_comb begin
    sh_d    = state_q == S_DIGIT ? sh_q << 4 : sh_q;
    cnt_d   = state_q == S_DIGIT ? cnt_q - 1'b1 : cnt_q;
    state_d = state_q == S_PREFIX ? S_DIGIT :
              state_q == S_DIGIT  ? (cnt_q == CW'(1) ? S_EOL : S_DIGIT) :
              state_q == S_CR     ? S_LF : S_IDLE;
  end

  always_ff @(posedge clock)
    if (push) mem_q[wr_q] <= in_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      state_q   <= S_IDLE;
      sh_q      <= '0;
      cnt_q     <= '0;
      tx_data_q <= 8'h00;
      tx_we_q   <= 1'b0;
    end else begin
      wr_q    <= wr_q + AW'(push);
      rd_q    <= rd_q + AW'(pop);
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
      if (pop) begin
        state_q <= S_FIRST;
        sh_q    <= SW'(mem_q[rd_q]);
        cnt_q   <= CW'(NIB);
      end else if (state_q != S_IDLE && !tx_we_q) begin
        tx_we_q   <= 1'b1;
        tx_data_q <= char_of(state_q, sh_q);
      end else if (consume) begin
        state_q <= state_d;
        sh_q    <= sh_d;
        cnt_q   <= cnt_d;
        tx_we_q <= state_d != S_IDLE;
        if (state_d != S_IDLE) tx_data_q <= char_of(state_d, sh_d);
      end
    end
  end
endmodule

// File: tb/tb_hex_word_tx.sv
// tb_hex_word_tx: scoreboard bench for hex_word_tx; expected bytes come from a
// digit-by-digit text model and are checked by independent monitors.
module tb_hex_word_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [35:0] in_data = '0;
  logic [7:0]  tx_data;
  logic        tx_we;
  logic        tx_busy = 1'b0;
  logic        idle;
  logic [2:0]  fifo_count;

  logic        iv1 = 1'b0, ir1, tw1, idl1;
  logic [13:0] id1 = '0;
  logic [7:0]  td1;
  logic [2:0]  fc1;
  logic        iv2 = 1'b0, ir2, tw2, idl2;
  logic [0:0]  id2 = '0;
  logic [7:0]  td2;
  logic [2:0]  fc2;

  hex_word_tx u0 (
    .clock(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .tx_data(tx_data), .tx_we(tx_we), .tx_busy(tx_busy), .idle(idle), .fifo_count(fifo_count)
  );

  hex_word_tx #(.WIDTH(14), .LOWERCASE(1'b1), .EOL(1), .PREFIX(8'h78)) u1 (
    .clock(clk), .reset(rst), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .tx_data(td1), .tx_we(tw1), .tx_busy(1'b0), .idle(idl1), .fifo_count(fc1)
  );

  hex_word_tx #(.WIDTH(1), .EOL(0), .PREFIX(8'h00)) u2 (
    .clock(clk), .reset(rst), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .tx_data(td2), .tx_we(tw2), .tx_busy(1'b0), .idle(idl2), .fifo_count(fc2)
  );

  int         tests = 0;
  int         fails = 0;
  logic [7:0] sb[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  int         busy_mode = 0;
  int         bcnt = 0;
  int         line_pos = 0;
  int         lines_done = 0;
  bit         hold_v = 1'b0;
  logic [7:0] hold_d = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference text for one default-configured word: nine upper-case hex digits, CR, LF.
  function automatic void exp_line(input logic [35:0] w);
    logic [3:0] d;
    for (int i = 8; i >= 0; i--) begin
      d = w[4*i +: 4];
      sb.push_back(d < 4'd10 ? 8'h30 + 8'(d) : 8'h41 + 8'(d) - 8'd10);
    end
    sb.push_back(8'h0D);
    sb.push_back(8'h0A);
  endfunction

  task automatic push0(input logic [35:0] w, output int c);
    int n;
    n = 0;
    c = -1;
    in_valid = 1'b1;
    in_data = w;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 3000) begin
        flag_fail("push_timeout");
        return;
      end
    end
    c = int'(fifo_count);
    @(posedge clk);
    #1;
    exp_line(w);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || !idle) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= budget) flag_fail({name, "_drain_timeout"});
    else chk({name, "_idle"}, idle, 1'b1);
    chk({name, "_sb_empty"}, sb.size(), 0);
  endtask

  // Busy generator: 0 free, 1 three-cycle pulse after each consume, 2 held, 3 random.
  always @(posedge clk) begin
    bit cons;
    cons = tx_we && !tx_busy;
    #1;
    if (busy_mode == 1) begin
      if (cons) begin
        tx_busy = 1'b1;
        bcnt = 2;
      end else if (bcnt > 0) begin
        bcnt--;
        tx_busy = 1'b1;
      end else tx_busy = 1'b0;
    end else tx_busy = busy_mode == 2 ? 1'b1 : busy_mode == 3 ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
      line_pos = 0;
    end else begin
      if (hold_v) begin
        chk("stable_we", tx_we, 1'b1);
        chk("stable_data", tx_data, hold_d);
      end
      hold_v = tx_we && tx_busy;
      hold_d = tx_data;
      if (tx_we && !tx_busy) begin
        if (sb.size() == 0) flag_fail($sformatf("unexpected_byte %0h", tx_data));
        else begin
          logic [7:0] e;
          e = sb.pop_front();
          chk("byte", tx_data, e);
          if (e == 8'h0A) begin
            line_pos = 0;
            lines_done++;
          end else line_pos++;
        end
      end
    end
  end

  always @(negedge clk)
    if (!rst && tw1) begin
      if (q1.size() == 0) flag_fail("u1_unexpected_byte");
      else chk("u1_byte", td1, q1.pop_front());
    end

  always @(negedge clk)
    if (!rst && tw2) begin
      if (q2.size() == 0) flag_fail("u2_unexpected_byte");
      else chk("u2_byte", td2, q2.pop_front());
    end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, n, target;
    logic [35:0] w;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_we", tx_we, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_idle", idle, 1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Narrow lower-case word with prefix and LF-only; 1-bit word with no framing.
    q1.push_back(8'h78); q1.push_back(8'h33); q1.push_back(8'h61);
    q1.push_back(8'h35); q1.push_back(8'h66); q1.push_back(8'h0A);
    q2.push_back(8'h31); q2.push_back(8'h30);
    iv1 = 1'b1; id1 = 14'h3A5F;
    iv2 = 1'b1; id2 = 1'b1;
    @(posedge clk);
    #1;
    iv1 = 1'b0;
    id2 = 1'b0;
    @(posedge clk);
    #1;
    iv2 = 1'b0;
    n = 0;
    while ((q1.size() != 0 || q2.size() != 0 || !idl1 || !idl2) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("u1_drained", q1.size(), 0);
    chk("u2_drained", q2.size(), 0);
    chk("u1_idle", idl1, 1'b1);
    chk("u2_idle", idl2, 1'b1);
    chk("u1_ready", ir1, 1'b1);
    chk("u2_count", fc2, 0);

    // First word into an empty block, with busy pulsing after every byte.
    busy_mode = 1;
    push0(36'h01234ABCD, c);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("lat_pop_no_we", tx_we, 1'b0);
    @(posedge clk);
    #1;
    chk("lat_first_we", tx_we, 1'b1);
    chk("lat_first_data", tx_data, 8'h30);
    drain("pulse", 500);

    // Fill with busy held: five accepted, sixth waits for space.
    busy_mode = 2;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 5; k++) push0(36'(k), c);
    in_data = 36'd6;
    repeat (3) @(posedge clk);
    #1;
    chk("full_count", fifo_count, 4);
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_we_held", tx_we, 1'b1);
    chk("full_data_held", tx_data, 8'h30);
    busy_mode = 0;
    push0(36'd6, c);
    chk("sixth_at_count3", c, 3);
    in_valid = 1'b0;
    drain("full", 2000);

    // Push aligned exactly with a pop while two words are queued.
    busy_mode = 2;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) push0(36'({$urandom(), $urandom()}), c);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("simul_pre_count", fifo_count, 2);
    target = lines_done + 1;
    busy_mode = 0;
    n = 0;
    while (lines_done != target && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (n >= 500) flag_fail("simul_line_timeout");
    #1;
    w = 36'({$urandom(), $urandom()});
    in_valid = 1'b1;
    in_data = w;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_line(w);
    chk("simul_count", fifo_count, 2);
    drain("simul", 2000);

    // Random words, random gaps, random back-pressure.
    busy_mode = 3;
    for (int k = 0; k < 12; k++) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      push0(36'({$urandom(), $urandom()}), c);
    end
    in_valid = 1'b0;
    drain("random", 4000);

    // Reset while the fourth digit is on the wire, with a second word queued.
    busy_mode = 1;
    push0(36'({$urandom(), $urandom()}), c);
    push0(36'({$urandom(), $urandom()}), c);
    in_valid = 1'b0;
    n = 0;
    while (line_pos != 3 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (n >= 500) flag_fail("rst_digit_timeout");
    #1;
    chk("pre_rst_count", fifo_count, 1);
    chk("pre_rst_we", tx_we, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_we", tx_we, 1'b0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_data", tx_data, 8'h00);
    chk("mid_rst_idle", idle, 1'b1);
    sb.delete();
    busy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    push0(36'h0, c);
    in_valid = 1'b0;
    drain("after_rst", 500);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
